alu_mc: RTL

Parametrised multi-cycle ALU, the successor to the 32-bit single-cycle combinational ALU. It keeps the AND/OR/ADD/SUB/SLT operations and the zero/set/overflow/cout flags, and adds XOR, iterative unsigned multiply and iterative unsigned divide. All outputs are registered, and operations are issued through a start/busy/done handshake. It sits in the execute stage and serves both single-cycle and long-latency instructions.

---
 rtl/alu_mc.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/adder ops plus iterative shift-add MULU
// and restoring DIVU, all results registered behind a start/busy/done handshake.
//
// Handshake: an op is accepted on a rising edge where start_i=1 and busy_o=0;
// done_o pulses for exactly one cycle when result/hi/flags become valid, and is
// never high together with busy_o. start_i while busy_o=1 is dropped.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] hi_o,
  output logic             cout_o,
  output logic             zero_o,
  output logic             set_o,
  output logic             overflow_o,
  output logic             divz_o,
  output logic [1:0]       state_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_MULU = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  work_hi_q, work_hi_d;
  logic [WIDTH-1:0]  work_lo_q, work_lo_d;
  logic [WIDTH-1:0]  opnd_q, opnd_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic              cout_q, cout_d;
  logic              zero_q, zero_d;
  logic              set_q, set_d;
  logic              ovf_q, ovf_d;
  logic              divz_q, divz_d;
  logic              done_q, done_d;

  // Shared adder; op[2] selects subtraction (two's complement of b).
  logic [WIDTH-1:0]  add_bin;
  logic              add_cin;
  logic [WIDTH:0]    add_full;
  logic [WIDTH-1:0]  add_sum;
  logic              add_ovf;
  logic              add_set;

  always_comb begin
    add_bin  = op_i[2] ? ~b_i : b_i;
    add_cin  = op_i[2];
    add_full = {1'b0, a_i} + {1'b0, add_bin} + {{WIDTH{1'b0}}, add_cin};
    add_sum  = add_full[WIDTH-1:0];
    add_ovf  = (a_i[WIDTH-1] == add_bin[WIDTH-1]) && (add_sum[WIDTH-1] != a_i[WIDTH-1]);
    add_set  = add_sum[WIDTH-1] ^ add_ovf;
  end

  // Multiply step: work_hi:work_lo holds partial product over the multiplier.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  // Divide step: work_hi is the partial remainder, work_lo shifts dividend out / quotient in.
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [WIDTH-1:0]   div_quo;

  always_comb begin
    mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    mul_next  = {mul_sum, work_lo_q[WIDTH-1:1]};
    div_shift = {work_hi_q, work_lo_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opnd_q};
    div_rem   = div_ge ? (div_shift[WIDTH-1:0] - opnd_q) : div_shift[WIDTH-1:0];
    div_quo   = {work_lo_q[WIDTH-2:0], div_ge};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_hi_d = work_hi_q;
    work_lo_d = work_lo_q;
    opnd_d    = opnd_q;
    result_d  = result_q;
    hi_d      = hi_q;
    cout_d    = cout_q;
    zero_d    = zero_q;
    set_d     = set_q;
    ovf_d     = ovf_q;
    divz_d    = divz_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (op_i == OP_MULU) begin
            state_d   = S_MUL;
            cnt_d     = '0;
            work_hi_d = '0;
            work_lo_d = a_i;
            opnd_d    = b_i;
          end else if (op_i == OP_DIVU && b_i != '0) begin
            state_d   = S_DIV;
            cnt_d     = '0;
            work_hi_d = '0;
            work_lo_d = a_i;
            opnd_d    = b_i;
          end else begin
            done_d = 1'b1;
            hi_d   = '0;
            cout_d = 1'b0;
            set_d  = 1'b0;
            ovf_d  = 1'b0;
            divz_d = 1'b0;
            case (op_i)
              OP_AND:         result_d = a_i & b_i;
              OP_OR:          result_d = a_i | b_i;
              OP_XOR:         result_d = a_i ^ b_i;
              OP_ADD, OP_SUB: result_d = add_sum;
              OP_SLT:         result_d = {{(WIDTH-1){1'b0}}, add_set};
              default: begin
                // Only DIVU by zero reaches here.
                result_d = '1;
                hi_d     = a_i;
                divz_d   = 1'b1;
              end
            endcase
            if (op_i == OP_ADD || op_i == OP_SUB || op_i == OP_SLT) begin
              cout_d = add_full[WIDTH];
              set_d  = add_set;
              ovf_d  = add_ovf;
            end
            zero_d = (result_d == '0);
          end
        end
      end
      S_MUL: begin
        cnt_d     = cnt_q + CW'(1);
        work_hi_d = mul_next[2*WIDTH-1:WIDTH];
        work_lo_d = mul_next[WIDTH-1:0];
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d  = S_IDLE;
          done_d   = 1'b1;
          result_d = mul_next[WIDTH-1:0];
          hi_d     = mul_next[2*WIDTH-1:WIDTH];
          zero_d   = (mul_next[WIDTH-1:0] == '0);
          cout_d   = 1'b0;
          set_d    = 1'b0;
          ovf_d    = 1'b0;
          divz_d   = 1'b0;
        end
      end
      S_DIV: begin
        cnt_d     = cnt_q + CW'(1);
        work_hi_d = div_rem;
        work_lo_d = div_quo;
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d  = S_IDLE;
          done_d   = 1'b1;
          result_d = div_quo;
          hi_d     = div_rem;
          zero_d   = (div_quo == '0);
          cout_d   = 1'b0;
          set_d    = 1'b0;
          ovf_d    = 1'b0;
          divz_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      work_hi_q <= '0;
      work_lo_q <= '0;
      opnd_q    <= '0;
      result_q  <= '0;
      hi_q      <= '0;
      cout_q    <= 1'b0;
      zero_q    <= 1'b0;
      set_q     <= 1'b0;
      ovf_q     <= 1'b0;
      divz_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_hi_q <= work_hi_d;
      work_lo_q <= work_lo_d;
      opnd_q    <= opnd_d;
      result_q  <= result_d;
      hi_q      <= hi_d;
      cout_q    <= cout_d;
      zero_q    <= zero_d;
      set_q     <= set_d;
      ovf_q     <= ovf_d;
      divz_q    <= divz_d;
      done_q    <= done_d;
    end
  end

  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = done_q;
  assign result_o   = result_q;
  assign hi_o       = hi_q;
  assign cout_o     = cout_q;
  assign zero_o     = zero_q;
  assign set_o      = set_q;
  assign overflow_o = ovf_q;
  assign divz_o     = divz_q;
  assign state_o    = state_q;

endmodule
